// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the iterative multiply/divide units and owns the architectural HI/LO registers.
// Latency: op sampled at edge N -> CLEAR(1) + RUN(CYCLES) + WRITE(1) busy cycles; HI/LO update on the edge leaving WRITE.
// Backpressure: busy stays high for the whole operation; new ops and HI/LO writes are dropped while busy.

module muldiv_ctrl #(
   parameter int MULT_CYCLES = 33,
   parameter int DIV_CYCLES  = 33,
   parameter int CNT_W       = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_mult,
   input  logic        op_div,
   input  logic [31:0] div_b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   output logic        mult_rst,
   output logic        mult_init,
   output logic        div_rst,
   output logic        div_init,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   // Sequencer states
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_WRITE = 2'd3;

   // Operation select
   localparam logic SEL_MUL = 1'b0;
   localparam logic SEL_DIV = 1'b1;

   // Last counter value seen in RUN for each unit
   localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

   // The counter must be able to hold the largest terminal value without wrapping
   generate
      if (((1 << CNT_W) <= MULT_CYCLES) || ((1 << CNT_W) <= DIV_CYCLES)) begin : g_bad_cnt_w
         $error("muldiv_ctrl: CNT_W too small for MULT_CYCLES/DIV_CYCLES");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic             sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             mult_rst_q, mult_rst_d;
   logic             mult_init_q, mult_init_d;
   logic             div_rst_q, div_rst_d;
   logic             div_init_q, div_init_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;
   logic [CNT_W-1:0] run_last;
   logic             divisor_zero;

   assign run_last     = (sel_q == SEL_DIV) ? DIV_LAST : MULT_LAST;
   assign divisor_zero = (div_b == 32'd0);

   // Next-state, op select and divide-by-zero detection; multiply wins over divide
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      div_zero_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (op_mult) begin
               sel_d   = SEL_MUL;
               state_d = S_CLEAR;
            end else if (op_div) begin
               if (divisor_zero) begin
                  div_zero_d = 1'b1;
               end else begin
                  sel_d   = SEL_DIV;
                  state_d = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (cnt_q == run_last) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Iteration counter: cleared in CLEAR, counts every RUN cycle, exits before it can wrap
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_CLEAR) begin
         cnt_d = '0;
      end else if (state_q == S_RUN) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // HI/LO: direct writes only when idle; the selected unit's result is captured in WRITE
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (state_q == S_IDLE) begin
         if (hi_we) begin
            hi_d = wdata;
         end
         if (lo_we) begin
            lo_d = wdata;
         end
      end else if (state_q == S_WRITE) begin
         hi_d = (sel_q == SEL_DIV) ? div_hi : mult_hi;
         lo_d = (sel_q == SEL_DIV) ? div_lo : mult_lo;
      end
   end

   // Unit controls and status decoded from the next state so they are registered
   always_comb begin
      mult_rst_d  = (state_d == S_CLEAR) && (sel_d == SEL_MUL);
      mult_init_d = (state_d == S_RUN)   && (sel_d == SEL_MUL);
      div_rst_d   = (state_d == S_CLEAR) && (sel_d == SEL_DIV);
      div_init_d  = (state_d == S_RUN)   && (sel_d == SEL_DIV);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_WRITE);
   end

   // State and datapath registers; reset aborts any operation without a unit clear pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         sel_q       <= SEL_MUL;
         cnt_q       <= '0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         mult_rst_q  <= 1'b0;
         mult_init_q <= 1'b0;
         div_rst_q   <= 1'b0;
         div_init_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         mult_rst_q  <= mult_rst_d;
         mult_init_q <= mult_init_d;
         div_rst_q   <= div_rst_d;
         div_init_q  <= div_init_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign mult_rst  = mult_rst_q;
   assign mult_init = mult_init_q;
   assign div_rst   = div_rst_q;
   assign div_init  = div_init_q;
   assign hi_out    = hi_q;
   assign lo_out    = lo_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl with behavioural mult/div unit models.
// Latency: expected results are pushed at issue and popped by a monitor on done/div_zero.
// Backpressure: stimulus waits for the scoreboard to drain before issuing the next op.

module tb_muldiv_ctrl;

   localparam int MC = 33;
   localparam int DC = 33;

   // Kinds of completion events
   localparam int K_MUL = 0;
   localparam int K_DIV = 1;
   localparam int K_DZ  = 2;

   typedef struct {
      int          kind;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        op_mult, op_div;
   logic [31:0] div_b;
   logic        hi_we, lo_we;
   logic [31:0] wdata;
   logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
   logic        mult_rst, mult_init, div_rst, div_init;
   logic [31:0] hi_out, lo_out;
   logic        busy, done, div_zero;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   logic [31:0] model_hi, model_lo;
   logic [63:0] m_prod;
   logic [31:0] d_q, d_r;
   int          mcnt, dcnt;

   // Monitor state
   int          mi, di, mr, dr, bc;
   bit          pend;
   logic [31:0] pend_hi, pend_lo;

   muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .op_mult(op_mult), .op_div(op_div), .div_b(div_b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
      .mult_rst(mult_rst), .mult_init(mult_init), .div_rst(div_rst), .div_init(div_init),
      .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .div_zero(div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unit models: results are only meaningful after the full iteration count
   always @(posedge clk or posedge reset) begin
      if (reset) mcnt <= 0;
      else if (mult_rst) mcnt <= 0;
      else if (mult_init) mcnt <= mcnt + 1;
   end
   always @(posedge clk or posedge reset) begin
      if (reset) dcnt <= 0;
      else if (div_rst) dcnt <= 0;
      else if (div_init) dcnt <= dcnt + 1;
   end
   assign mult_hi = (mcnt == MC) ? m_prod[63:32] : 32'hDEAD_BEEF;
   assign mult_lo = (mcnt == MC) ? m_prod[31:0]  : 32'hBAAD_F00D;
   assign div_hi  = (dcnt == DC) ? d_r : 32'hC0DE_0001;
   assign div_lo  = (dcnt == DC) ? d_q : 32'hC0DE_0002;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports a completion
   initial begin
      int   act_kind;
      exp_t e;
      mi = 0; di = 0; mr = 0; dr = 0; bc = 0; pend = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mi = 0; di = 0; mr = 0; dr = 0; bc = 0; pend = 0;
         end else begin
            if (pend) begin
               check("hi_after", {32'd0, hi_out}, {32'd0, pend_hi});
               check("lo_after", {32'd0, lo_out}, {32'd0, pend_lo});
               check("busy_after", {63'd0, busy}, 64'd0);
               pend = 0;
            end
            if (mult_init) mi++;
            if (div_init)  di++;
            if (mult_rst)  mr++;
            if (div_rst)   dr++;
            if (busy)      bc++;
            if (done || div_zero) begin
               if (done && div_zero) act_kind = -1;
               else if (div_zero) act_kind = K_DZ;
               else if (di != 0) act_kind = K_DIV;
               else act_kind = K_MUL;
               if (sb.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL spurious_event: got kind %0d expected none", act_kind);
               end else begin
                  e = sb.pop_front();
                  check("event_kind", 64'(act_kind), 64'(e.kind));
                  if (e.kind == K_DZ) begin
                     check("dz_busy_cycles", 64'(bc), 64'd0);
                     check("dz_unit_activity", 64'(mi + di + mr + dr), 64'd0);
                  end else if (e.kind == K_MUL) begin
                     check("mul_init_cycles", 64'(mi), 64'(MC));
                     check("mul_rst_cycles", 64'(mr), 64'd1);
                     check("mul_div_idle", 64'(di + dr), 64'd0);
                     check("mul_busy_cycles", 64'(bc), 64'(MC + 2));
                  end else begin
                     check("div_init_cycles", 64'(di), 64'(DC));
                     check("div_rst_cycles", 64'(dr), 64'd1);
                     check("div_mul_idle", 64'(mi + mr), 64'd0);
                     check("div_busy_cycles", 64'(bc), 64'(DC + 2));
                  end
                  pend    = 1;
                  pend_hi = e.hi;
                  pend_lo = e.lo;
               end
               mi = 0; di = 0; mr = 0; dr = 0; bc = 0;
            end
         end
      end
   end

   // Issue one idle-cycle request; the model decides what the architecture must end up with
   task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input bit hwe, input bit lwe, input logic [31:0] wd);
      exp_t e;
      logic signed [63:0] sa, sb64, p;
      logic signed [31:0] q, r;
      if (hwe) model_hi = wd;
      if (lwe) model_lo = wd;
      if (m) begin
         sa   = {{32{a[31]}}, a};
         sb64 = {{32{b[31]}}, b};
         p    = sa * sb64;
         m_prod   = p;
         model_hi = p[63:32];
         model_lo = p[31:0];
         e = '{kind: K_MUL, hi: model_hi, lo: model_lo};
         sb.push_back(e);
      end else if (d) begin
         if (b != 32'd0) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            d_q = q;
            d_r = r;
            model_hi = r;
            model_lo = q;
            e = '{kind: K_DIV, hi: model_hi, lo: model_lo};
         end else begin
            e = '{kind: K_DZ, hi: model_hi, lo: model_lo};
         end
         sb.push_back(e);
      end
      div_b = b; op_mult = m; op_div = d; hi_we = hwe; lo_we = lwe; wdata = wd;
      @(negedge clk);
      op_mult = 0; op_div = 0; hi_we = 0; lo_we = 0;
   endtask

   // Drive inputs during a busy period; all of them must be ignored
   task automatic pulse_busy(input bit m, input bit d, input logic [31:0] b,
                             input bit hwe, input bit lwe, input logic [31:0] wd);
      div_b = b; op_mult = m; op_div = d; hi_we = hwe; lo_we = lwe; wdata = wd;
      @(negedge clk);
      op_mult = 0; op_div = 0; hi_we = 0; lo_we = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((sb.size() != 0 || pend) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_done_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ctl"}, {57'd0, mult_rst, mult_init, div_rst, div_init, busy, done, div_zero}, 64'd0);
      check({name, "_hi"}, {32'd0, hi_out}, 64'd0);
      check({name, "_lo"}, {32'd0, lo_out}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a, b;
      int          sel;
      reset = 1; op_mult = 0; op_div = 0; div_b = 0; hi_we = 0; lo_we = 0; wdata = 0;
      m_prod = 0; d_q = 0; d_r = 0; model_hi = 0; model_lo = 0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 0;
      @(negedge clk);

      // -3 * 2
      issue(1, 0, 32'hFFFF_FFFD, 32'd2, 0, 0, 32'd0);
      wait_done();
      check("mul_hi_const", {32'd0, hi_out}, 64'h0000_0000_FFFF_FFFF);
      check("mul_lo_const", {32'd0, lo_out}, 64'h0000_0000_FFFF_FFFA);

      // 37 / 7
      issue(0, 1, 32'd37, 32'd7, 0, 0, 32'd0);
      wait_done();
      check("div_hi_const", {32'd0, hi_out}, 64'd2);
      check("div_lo_const", {32'd0, lo_out}, 64'd5);

      // preset HI/LO then divide by zero
      issue(0, 0, 32'd0, 32'd0, 1, 0, 32'h11);
      issue(0, 0, 32'd0, 32'd0, 0, 1, 32'h22);
      check("preset_hi", {32'd0, hi_out}, 64'h11);
      check("preset_lo", {32'd0, lo_out}, 64'h22);
      issue(0, 1, 32'd100, 32'd0, 0, 0, 32'd0);
      wait_done();
      check("dz_hi_kept", {32'd0, hi_out}, 64'h11);
      check("dz_lo_kept", {32'd0, lo_out}, 64'h22);

      // mthi while busy is dropped, then mthi in idle lands
      issue(1, 0, 32'd1234567, 32'hFFFF_0001, 0, 0, 32'd0);
      repeat (5) @(negedge clk);
      pulse_busy(0, 0, 32'd0, 1, 0, 32'hAAAA_0000);
      wait_done();
      check("busy_write_ignored", {32'd0, hi_out}, {32'd0, model_hi});
      issue(0, 0, 32'd0, 32'd0, 1, 0, 32'h1234);
      check("mthi_idle", {32'd0, hi_out}, 64'h1234);
      check("mthi_lo_unchanged", {32'd0, lo_out}, {32'd0, model_lo});

      // simultaneous mult/div, then a divide request during RUN
      issue(1, 1, 32'h7FFF_FFFF, 32'd7, 0, 0, 32'd0);
      repeat (10) @(negedge clk);
      pulse_busy(0, 1, 32'd9, 0, 1, 32'h5A5A);
      wait_done();
      repeat (3) @(negedge clk);
      check("no_extra_events", 64'(sb.size()), 64'd0);

      // writes in the same cycle as an accepted op are overwritten by the result
      issue(1, 0, 32'hFFFF_F000, 32'h0000_0123, 1, 1, 32'h5555_5555);
      wait_done();

      // reset ten cycles into RUN
      issue(1, 0, 32'd99, 32'd99, 0, 0, 32'd0);
      repeat (10) @(negedge clk);
      #2 reset = 1;
      #1 check_all_zero("abort");
      sb.delete();
      model_hi = 0;
      model_lo = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      issue(1, 0, 32'hFFFF_FFF9, 32'hFFFF_FFF5, 0, 0, 32'd0);
      wait_done();
      check("post_abort_lo", {32'd0, lo_out}, 64'd77);

      // randomized mix
      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 5);
         a = $urandom;
         b = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(1, 20);
         if (b == 32'd0) b = 32'd1;
         case (sel)
            0, 1: issue(1, 0, a, b, 0, 0, 32'd0);
            2: begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
               issue(0, 1, a, b, 0, 0, 32'd0);
            end
            3: issue(0, 1, a, 32'd0, 0, 0, 32'd0);
            4: begin
               issue(0, 0, 32'd0, 32'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
               check("rnd_wr_hi", {32'd0, hi_out}, {32'd0, model_hi});
               check("rnd_wr_lo", {32'd0, lo_out}, {32'd0, model_lo});
            end
            default: issue(1, 0, a, b, 1, 1, $urandom);
         endcase
         wait_done();
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
